// File: rtl/calc_param_if.sv
// Keypad-command / display-stream bundle between the calculator core and its neighbours.
// The master side issues commands and consumes the digit stream; the slave is the core.
interface calc_param_if #(
  parameter int unsigned PW = 4
) ();
  logic          cmd_valid;
  logic [3:0]    cmd;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic          frame_valid;
  logic          neg;

  modport master (
    output cmd_valid, cmd,
    input  status, data, pos, frame_valid, neg
  );

  modport slave (
    input  cmd_valid, cmd,
    output status, data, pos, frame_valid, neg
  );
endinterface

// File: rtl/calc_param.sv
// Parametrised keypad calculator core: operand entry, add/sub/mul/div execution with range
// checking, and a one-digit-per-cycle BCD stream of the current value after every command.
module calc_param #(
  parameter int unsigned NDIG = 8,
  parameter int unsigned W    = 27,
  parameter int unsigned PW   = 4
) (
  input logic         clock,
  input logic         reset,
  calc_param_if.slave bus
);

  typedef enum logic [2:0] {StEntryA, StOpWait, StEntryB, StExec, StShow, StErr} state_e;
  typedef enum logic [2:0] {OpNone, OpAdd, OpSub, OpMul, OpDiv} op_e;

  localparam logic [W-1:0] Max = W'(10 ** NDIG - 1);

  state_e        state_q, state_d, ret_q, ret_d;
  op_e           op_q, op_d;
  logic [W-1:0]  value_q, value_d, rega_q, rega_d, regb_q, regb_d;
  logic [W-1:0]  count_q, count_d, acc_q, acc_d, aux_q, aux_d, sh_q, sh_d;
  logic [3:0]    data_q, data_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          fv_q, fv_d, neg_q, neg_d, res_q, res_d, setup_q, setup_d;

  logic          accept, is_digit, is_op, digit_fits, go_err, show_go, ge;
  logic [W-1:0]  appended, show_val, mn, mx, quo_nx;
  logic [W:0]    add_sum, mul_sum, rem_sh;

  assign accept     = bus.cmd_valid && (state_q inside {StEntryA, StOpWait, StEntryB});
  assign is_digit   = bus.cmd <= 4'd9;
  assign is_op      = bus.cmd inside {[4'd10 : 4'd13]};
  assign digit_fits = value_q <= (Max - W'(bus.cmd)) / W'(10);
  assign appended   = digit_fits ? value_q * W'(10) + W'(bus.cmd) : value_q;
  assign add_sum    = {1'b0, rega_q} + {1'b0, regb_q};
  assign mul_sum    = {1'b0, acc_q} + {1'b0, aux_q};
  assign mn         = (rega_q < regb_q) ? rega_q : regb_q;
  assign mx         = (rega_q < regb_q) ? regb_q : rega_q;
  // Restoring division: acc holds the partial remainder, aux shifts dividend out / quotient in.
  assign rem_sh     = {acc_q, aux_q[W-1]};
  assign ge         = rem_sh >= {1'b0, regb_q};
  assign quo_nx     = {aux_q[W-2:0], ge};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StEntryA;
      ret_q   <= StEntryA;
      op_q    <= OpNone;
      value_q <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      count_q <= '0;
      acc_q   <= '0;
      aux_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      pos_q   <= '0;
      fv_q    <= 1'b0;
      neg_q   <= 1'b0;
      res_q   <= 1'b0;
      setup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      op_q    <= op_d;
      value_q <= value_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      aux_q   <= aux_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      pos_q   <= pos_d;
      fv_q    <= fv_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      setup_q <= setup_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    op_d     = op_q;
    value_d  = value_q;
    rega_d   = rega_q;
    regb_d   = regb_q;
    count_d  = count_q;
    acc_d    = acc_q;
    aux_d    = aux_q;
    sh_d     = sh_q;
    data_d   = data_q;
    pos_d    = pos_q;
    fv_d     = fv_q;
    neg_d    = neg_q;
    res_d    = res_q;
    setup_d  = setup_q;
    go_err   = 1'b0;
    show_go  = 1'b0;
    show_val = value_q;

    unique case (state_q)
      StEntryA, StOpWait, StEntryB: begin
        if (accept) begin
          show_go = 1'b1;
          ret_d   = state_q;
          if (is_digit) begin
            if (state_q == StOpWait) begin
              show_val = W'(bus.cmd);
              ret_d    = StEntryB;
            end else if (state_q == StEntryA && res_q) begin
              show_val = W'(bus.cmd);
              neg_d    = 1'b0;
              res_d    = 1'b0;
            end else begin
              show_val = appended;
            end
          end else if (is_op) begin
            if (state_q == StEntryB || (state_q == StEntryA && neg_q)) begin
              go_err = 1'b1;
            end else begin
              if (state_q == StEntryA) rega_d = value_q;
              op_d  = op_e'(3'(bus.cmd - 4'd9));
              ret_d = StOpWait;
              res_d = 1'b0;
            end
          end else if (bus.cmd == 4'd14) begin
            if (state_q == StEntryB) begin
              show_go = 1'b0;
              regb_d  = value_q;
              state_d = StExec;
              setup_d = 1'b1;
            end
          end else begin
            show_val = value_q / W'(10);
            neg_d    = 1'b0;
            res_d    = 1'b0;
          end
        end
      end
      StExec: begin
        if (setup_q) begin
          setup_d = 1'b0;
          neg_d   = 1'b0;
          unique case (op_q)
            OpAdd: begin
              if (add_sum > {1'b0, Max}) go_err = 1'b1;
              else begin
                show_go  = 1'b1;
                show_val = add_sum[W-1:0];
              end
            end
            OpSub: begin
              show_go  = 1'b1;
              neg_d    = rega_q < regb_q;
              show_val = (rega_q < regb_q) ? regb_q - rega_q : rega_q - regb_q;
            end
            OpMul: begin
              if (mn == '0) begin
                show_go  = 1'b1;
                show_val = '0;
              end else begin
                count_d = mn;
                aux_d   = mx;
                acc_d   = '0;
              end
            end
            OpDiv: begin
              if (regb_q == '0) go_err = 1'b1;
              else begin
                count_d = W'(W);
                aux_d   = rega_q;
                acc_d   = '0;
              end
            end
            default: go_err = 1'b1;
          endcase
        end else if (op_q == OpMul) begin
          if (mul_sum > {1'b0, Max}) go_err = 1'b1;
          else begin
            acc_d   = mul_sum[W-1:0];
            count_d = count_q - W'(1);
            if (count_q == W'(1)) begin
              show_go  = 1'b1;
              show_val = mul_sum[W-1:0];
            end
          end
        end else begin
          acc_d   = ge ? W'(rem_sh - {1'b0, regb_q}) : rem_sh[W-1:0];
          aux_d   = quo_nx;
          count_d = count_q - W'(1);
          if (count_q == W'(1)) begin
            show_go  = 1'b1;
            show_val = quo_nx;
          end
        end
        if (show_go) begin
          ret_d = StEntryA;
          res_d = 1'b1;
        end
      end
      StShow: begin
        if (pos_q == PW'(NDIG - 1)) begin
          state_d = ret_q;
          fv_d    = 1'b0;
        end else begin
          pos_d  = pos_q + PW'(1);
          data_d = 4'(sh_q % W'(10));
          sh_d   = sh_q / W'(10);
        end
      end
      default: ;
    endcase

    if (go_err) begin
      state_d = StErr;
      data_d  = 4'hF;
      pos_d   = '0;
      fv_d    = 1'b0;
    end else if (show_go) begin
      state_d = StShow;
      value_d = show_val;
      data_d  = 4'(show_val % W'(10));
      sh_d    = show_val / W'(10);
      pos_d   = '0;
      fv_d    = 1'b1;
    end
  end

  always_comb begin
    unique case (state_q)
      StExec, StShow: bus.status = 2'b01;
      StErr:          bus.status = 2'b00;
      default:        bus.status = 2'b10;
    endcase
  end

  assign bus.data        = data_q;
  assign bus.pos         = pos_q;
  assign bus.frame_valid = fv_q;
  assign bus.neg         = neg_q;

endmodule

// File: doc/calc_param.md
Name: calc_param

Overview:
- Parametrised successor of the 4-bit-keypad calculator core. Accepts decimal key commands, builds two operands, and executes add, subtract, multiply or divide.
- Multiply is successive addition; divide is restoring division. Results are range-checked.
- After every accepted command, streams the current value to the multiplexed display one digit per cycle (data/pos).
- Sits between the keypad decoder and the 7-segment scan driver.

Parameters:
- NDIG, 8, number of decimal display digits; operand and result magnitude limit is 10^NDIG-1.
- W, 27, operand/accumulator width in bits; must satisfy 2^W > 10^NDIG-1.
- PW, 4, width of pos; must satisfy 2^PW >= NDIG.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising clock edge; 0 = reset).
- cmd_valid  in  1  cmd strobe; accepted only in a cycle where status==READY.
- cmd  in  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 backspace.
- status  out  2  00 ERROR, 01 BUSY, 10 READY (11 never driven).
- data  out  4  BCD digit for position pos; valid when frame_valid=1.
- pos  out  PW  digit index, 0 = least significant.
- frame_valid  out  1  data/pos valid this cycle.
- neg  out  1  displayed value is negative (magnitude shown on data).

Behaviour:
- Reset (reset==0 at edge): state ENTRY_A; value/regA/regB/count=0; op=none; status=READY; data=0; pos=0; frame_valid=0; neg=0. Reset overrides any in-progress EXEC or SHOW.
- States: ENTRY_A, OP_WAIT, ENTRY_B, EXEC, SHOW, ERR. SHOW records a return state.
- Accept at edge k means cmd_valid && status==READY. status is BUSY from k+1 until the scan ends. cmd_valid while BUSY is ignored; there is no queueing.
- Digit entry (ENTRY_A/ENTRY_B): value=value*10+cmd, only if value<=(10^NDIG-1-cmd)/10 after the check. Otherwise the digit is dropped, but a scan still occurs.
- Backspace: value=value/10; value 0 stays 0. Clears neg.
- Operator (10-13) in ENTRY_A: regA=value, op=cmd, goto OP_WAIT.
- Operator in OP_WAIT: replaces op, no error.
- Operator in ENTRY_B: goto ERR.
- Digit in OP_WAIT: value=cmd, goto ENTRY_B.
- Equals in ENTRY_A or OP_WAIT: no-op scan.
- Equals in ENTRY_B: regB=value, goto EXEC.
- EXEC latency, measured from accept to start of scan:
  - add/sub: 1 cycle.
  - mul: 1 setup cycle plus min(A,B) add cycles. count=min, addend=max. Operand 0 gives 1 cycle.
  - div: 1 setup cycle plus W cycles, quotient only, truncating.
- Range rules:
  - sub with A<B: result |A-B|, neg=1.
  - Result > 10^NDIG-1, or any intermediate mul sum exceeding it: goto ERR.
  - div with B=0: goto ERR.
- After EXEC: value=result, return state ENTRY_A with a "result" flag set.
- In ENTRY_A with the result flag set:
  - A digit first clears value and neg, then appends.
  - An operator uses the result as regA (chaining). A negative result used as an operand goes to ERR.
- SHOW: cycles s+0..s+NDIG-1 drive frame_valid=1, pos=i, data=(value/10^i)%10, one divide-by-10 stage per cycle. Leading zeros are shown.
- Display latency:
  - Entry commands: frames on k+1..k+NDIG; status READY at k+NDIG+1.
  - EXEC commands: frames start the cycle after EXEC ends.
- Outside SHOW: frame_valid=0; data/pos hold their last values.
- ERR: status=00; frame_valid=0; data=4'hF; pos=0. All cmds are ignored until reset.

Test Plan:
- reset low 2 cycles, then high -> status=10, frame_valid=0, neg=0. cmd 1,2 each accepted -> after second scan frames show pos0=2, pos1=1, pos2..7=0; READY exactly NDIG+1 cycles after each accept.
- 123, backspace, +, 45, = -> frames show 57 (data 7,5,0..0), neg=0. Then cmd 12 (mul), 3, = -> shows 171 (chaining).
- 7 - 19 = -> shows 12 with neg=1. Then digit 4 -> shows 4, neg=0.
- 25 * 4 = -> status BUSY for 1+4 EXEC cycles plus NDIG scan cycles, then shows 100. Also 99999999 * 2 = -> status=00, data=F; further cmds ignored; reset restores READY.
- 100 / 7 = -> shows 14; 5 / 0 = -> ERR. Also assert reset mid-EXEC of 5000*6000 -> next cycle status=10, value 0.
- Pulse cmd_valid with cmd=9 while BUSY -> ignored, displayed value unchanged. 8 digits entered then a 9th digit -> 9th dropped, scan still issued.
